rca_err_monitor: RTL and testbench
==================================

// Module: rca_err_monitor
// PURPOSE
//  Downstream consumer of the (approximate) ripple carry adder. Samples each operand set
//  A/B/CIN and the adder's SUM/COUT, recomputes the exact result and accumulates error stats:
//  sample count, erroneous-sample count, error-distance sum. Runs a bounded measurement
//  window under a START/DONE handshake; results are read by the bench or a host.
// PARAMETERS
//  WIDTH  4   operand width; matches the adder's WIDTH parameter
//  CNT_W  16  width of NUM_SAMPLES, SAMPLE_CNT, ERR_CNT
//  ACC_W  24  width of ED_SUM (must be >= WIDTH+1)
// PORTS
//  CLK          in   1         clock, rising edge
//  RST_N        in   1         reset, asynchronous, active-low
//  START        in   1         pulse: begin window (honoured in IDLE/DONE only)
//  CLEAR        in   1         sync clear: zero all stats, return to IDLE
//  NUM_SAMPLES  in   CNT_W     window length, captured on accepted START
//  VALID_IN     in   1         A/B/CIN/SUM/COUT valid this cycle
//  A, B         in   WIDTH     adder operands
//  CIN          in   1         adder carry-in
//  SUM          in   WIDTH     adder sum under test
//  COUT         in   1         adder carry-out under test
//  BUSY         out  1         high in RUN or DRAIN
//  DONE         out  1         high in DONE; held until START or CLEAR
//  SAMPLE_CNT   out  CNT_W     samples accumulated
//  ERR_CNT      out  CNT_W     samples with ED != 0
//  ED_SUM       out  ACC_W     sum of error distances
// BEHAVIOUR
//  - Reset (RST_N=0, async): state=IDLE, pipeline valid=0, every output and counter = 0.
//  - Arithmetic: EXACT = A+B+CIN, WIDTH+1 bits, unsigned. APPROX = {COUT,SUM}.
//    ED = |EXACT-APPROX|, WIDTH+1 bits, unsigned.
//  - Pipeline: stage 1 registers ED and ED!=0. Stage 2 updates the counters.
//    Counters reflect a sample 2 cycles after its VALID_IN edge.
//  - FSM states IDLE, RUN, DRAIN, DONE.
//    IDLE/DONE --START--> RUN: zero the counters, latch NUM_SAMPLES, accepted count := 0.
//    RUN: a sample is accepted when VALID_IN=1 and accepted < NUM_SAMPLES. Gaps
//    (VALID_IN=0) are allowed. When the accepted count reaches NUM_SAMPLES -> DRAIN.
//    DRAIN: wait until the pipeline is empty (2 cycles), then -> DONE.
//    NUM_SAMPLES=0: RUN -> DRAIN on the next cycle, with all counters 0.
//  - VALID_IN is ignored outside RUN. START is ignored in RUN/DRAIN.
//  - CLEAR has priority over START and VALID_IN: it zeroes counters and pipeline and
//    forces IDLE next cycle, including mid-RUN.
//  - Saturation: ED_SUM and ERR_CNT stick at all-ones and never wrap. SAMPLE_CNT cannot
//    exceed NUM_SAMPLES.
//  - RST_N asserted mid-window aborts immediately. No partial results are kept.
// CONFIGURATION
//  MAX_ED_TRACK_EN defined: adds outputs ED_MAX[WIDTH+1], MAX_A[WIDTH], MAX_B[WIDTH],
//  MAX_CIN[1]. These hold the largest ED seen in the window and the first operand set
//  producing it (update only on strictly greater ED). They reset/clear/START to 0.
//  MAX_ED_TRACK_EN undefined: these ports and their logic are absent. Everything else is
//  identical.
// TESTING (WIDTH=4)
//  1. START, NUM_SAMPLES=3. Three samples: A=3,B=12,CIN=0,SUM=15,COUT=0
//     -> DONE=1, SAMPLE_CNT=3, ERR_CNT=0, ED_SUM=0.
//  2. NUM_SAMPLES=2. Sample A=11,B=12,CIN=1,SUM=0,COUT=1 (ED=8), then
//     A=3,B=4,CIN=1,SUM=7,COUT=0 (ED=1)
//     -> ERR_CNT=2, ED_SUM=9; with MAX_ED_TRACK_EN: ED_MAX=8, MAX_A=11, MAX_B=12, MAX_CIN=1.
//  3. NUM_SAMPLES=4 with VALID_IN gaps. Pulse CLEAR after 2 samples
//     -> next cycle IDLE, BUSY=0, all counters 0. Later samples are ignored.
//  4. ACC_W=5, NUM_SAMPLES=6, each ED=8 -> ED_SUM saturates at 31, ERR_CNT=6.
//  5. NUM_SAMPLES=0 -> DONE within 4 cycles of START, all counters 0. Extra VALID_IN ignored.
//  6. RST_N low mid-RUN -> outputs 0 asynchronously. After release, START runs a fresh window.

Source files
------------

// File: rtl/rca_err_monitor.sv
// rca_err_monitor: error-statistics monitor for an approximate ripple carry adder.
// Each accepted sample (A, B, CIN vs. SUM, COUT) is compared against the exact sum.
// Over one START/DONE window it accumulates the sample count, the count of erroneous
// samples and the saturating sum of error distances.
// Optional feature: define MAX_ED_TRACK_EN to add ED_MAX / MAX_A / MAX_B / MAX_CIN,
// which report the largest error distance in the window and the first operands causing it.
module rca_err_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             CLEAR,
    input  logic [CNT_W-1:0] NUM_SAMPLES,
    input  logic             VALID_IN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic [WIDTH-1:0] SUM,
    input  logic             COUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] SAMPLE_CNT,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [ACC_W-1:0] ED_SUM
`ifdef MAX_ED_TRACK_EN
    ,
    output logic [WIDTH:0]   ED_MAX,
    output logic [WIDTH-1:0] MAX_A,
    output logic [WIDTH-1:0] MAX_B,
    output logic             MAX_CIN
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Window control
    logic             start_ok;
    logic             accept;
    logic             flush;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W:0]   acc_cnt_next;

    // Error distance of the sample currently presented
    logic [WIDTH:0]   exact;
    logic [WIDTH:0]   approx;
    logic [WIDTH:0]   ed;

    // Stage 1 pipeline register
    logic             s1_valid;
    logic [WIDTH:0]   s1_ed;
    logic             s1_err;

    // Stage 2 accumulators
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [ACC_W-1:0] ed_sum;
    logic [ACC_W:0]   ed_sum_wide;

`ifdef MAX_ED_TRACK_EN
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [WIDTH:0]   ed_max;
    logic [WIDTH-1:0] max_a;
    logic [WIDTH-1:0] max_b;
    logic             max_cin;
`endif

    // Exact reference sum and absolute distance to the adder's result
    always_comb begin
        exact  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CIN};
        approx = {COUT, SUM};
        if (exact >= approx) begin
            ed = exact - approx;
        end else begin
            ed = approx - exact;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state, sample acceptance and status outputs
    always_comb begin
        state_next   = state;
        start_ok     = 1'b0;
        accept       = 1'b0;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        acc_cnt_next = {1'b0, acc_cnt};
        case (state)
            S_IDLE: begin
                if (START) begin
                    start_ok   = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                BUSY         = 1'b1;
                accept       = VALID_IN && (acc_cnt < num_lat);
                acc_cnt_next = {1'b0, acc_cnt} + {{CNT_W{1'b0}}, accept};
                // Leave RUN on the same edge that captures the last sample, so a
                // zero-length window drops straight to DRAIN on its first cycle.
                if (acc_cnt_next >= {1'b0, num_lat}) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                BUSY = 1'b1;
                if (!s1_valid) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                DONE = 1'b1;
                if (START) begin
                    start_ok   = 1'b1;
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // CLEAR overrides any START or sample in the same cycle
        if (CLEAR) begin
            state_next = S_IDLE;
            start_ok   = 1'b0;
            accept     = 1'b0;
        end
    end

    assign flush = CLEAR | start_ok;

    // Window length latch and accepted-sample count
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            num_lat <= '0;
            acc_cnt <= '0;
        end else if (CLEAR) begin
            acc_cnt <= '0;
        end else if (start_ok) begin
            num_lat <= NUM_SAMPLES;
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt_next[CNT_W-1:0];
        end
    end

    // Stage 1: register error distance and error flag of each accepted sample
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
            s1_err   <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_ed  <= ed;
                s1_err <= (ed != '0);
            end
        end
    end

    assign ed_sum_wide = {1'b0, ed_sum} + {{(ACC_W - WIDTH){1'b0}}, s1_ed};

    // Stage 2: saturating statistics accumulation
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
        end else if (flush) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
        end else if (s1_valid) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (s1_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (ed_sum_wide[ACC_W]) begin
                ed_sum <= '1;
            end else begin
                ed_sum <= ed_sum_wide[ACC_W-1:0];
            end
        end
    end

    assign SAMPLE_CNT = sample_cnt;
    assign ERR_CNT    = err_cnt;
    assign ED_SUM     = ed_sum;

`ifdef MAX_ED_TRACK_EN
    // Stage 1 operand copy for maximum-error attribution
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_a   <= '0;
            s1_b   <= '0;
            s1_cin <= 1'b0;
        end else if (flush) begin
            s1_a   <= '0;
            s1_b   <= '0;
            s1_cin <= 1'b0;
        end else if (accept) begin
            s1_a   <= A;
            s1_b   <= B;
            s1_cin <= CIN;
        end
    end

    // Stage 2: track the largest error distance; ties keep the earlier operands
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ed_max  <= '0;
            max_a   <= '0;
            max_b   <= '0;
            max_cin <= 1'b0;
        end else if (flush) begin
            ed_max  <= '0;
            max_a   <= '0;
            max_b   <= '0;
            max_cin <= 1'b0;
        end else if (s1_valid && (s1_ed > ed_max)) begin
            ed_max  <= s1_ed;
            max_a   <= s1_a;
            max_b   <= s1_b;
            max_cin <= s1_cin;
        end
    end

    assign ED_MAX  = ed_max;
    assign MAX_A   = max_a;
    assign MAX_B   = max_b;
    assign MAX_CIN = max_cin;
`endif

endmodule

// File: tb/tb_rca_err_monitor.sv
// tb_rca_err_monitor: directed and randomized windows for rca_err_monitor, with a
// sample-list reference model. A second instance with ACC_W=5 shows ED_SUM saturation.
module tb_rca_err_monitor;

    localparam int WIDTH = 4;
    localparam int CNT_W = 16;

    typedef struct {
        int a;
        int b;
        int cin;
        int sum;
        int cout;
    } sample_t;

    logic             CLK;
    logic             RST_N;
    logic             START;
    logic             CLEAR;
    logic [CNT_W-1:0] NUM_SAMPLES;
    logic             VALID_IN;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic [WIDTH-1:0] SUM;
    logic             COUT;

    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [23:0]      ed_sum;

    logic             busy_s;
    logic             done_s;
    logic [CNT_W-1:0] sample_cnt_s;
    logic [CNT_W-1:0] err_cnt_s;
    logic [4:0]       ed_sum_s;

    int tests = 0;
    int fails = 0;
    sample_t q[$];

    rca_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(24)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .CLEAR(CLEAR),
        .NUM_SAMPLES(NUM_SAMPLES), .VALID_IN(VALID_IN), .A(A), .B(B), .CIN(CIN),
        .SUM(SUM), .COUT(COUT), .BUSY(busy), .DONE(done), .SAMPLE_CNT(sample_cnt),
        .ERR_CNT(err_cnt), .ED_SUM(ed_sum)
    );

    rca_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(5)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .START(START), .CLEAR(CLEAR),
        .NUM_SAMPLES(NUM_SAMPLES), .VALID_IN(VALID_IN), .A(A), .B(B), .CIN(CIN),
        .SUM(SUM), .COUT(COUT), .BUSY(busy_s), .DONE(done_s), .SAMPLE_CNT(sample_cnt_s),
        .ERR_CNT(err_cnt_s), .ED_SUM(ed_sum_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int ed_of(input sample_t s);
        int ex;
        int ap;
        ex = s.a + s.b + s.cin;
        ap = s.cout * 16 + s.sum;
        return (ex >= ap) ? ex - ap : ap - ex;
    endfunction

    function automatic sample_t rand_sample();
        sample_t s;
        int ex;
        int ap;
        s.a   = int'($urandom_range(0, 15));
        s.b   = int'($urandom_range(0, 15));
        s.cin = int'($urandom_range(0, 1));
        ex    = s.a + s.b + s.cin;
        case ($urandom_range(0, 2))
            0: ap = ex;
            1: ap = ex ^ (1 << $urandom_range(0, 4));
            default: ap = int'($urandom_range(0, 31));
        endcase
        s.sum  = ap % 16;
        s.cout = ap / 16;
        return s;
    endfunction

    task automatic drive_sample(input sample_t s);
        logic [31:0] v;
        v = s.a;    A   = v[3:0];
        v = s.b;    B   = v[3:0];
        v = s.cin;  CIN = v[0];
        v = s.sum;  SUM = v[3:0];
        v = s.cout; COUT = v[0];
        VALID_IN = 1'b1;
    endtask

    task automatic check_counts(input string tag, input int cnt, input int errs, input int eds);
        int sat;
        sat = (eds > 31) ? 31 : eds;
        check({tag, "_sample_cnt"}, sample_cnt, cnt);
        check({tag, "_err_cnt"}, err_cnt, errs);
        check({tag, "_ed_sum"}, ed_sum, eds);
        check({tag, "_sat_ed_sum"}, ed_sum_s, sat);
        check({tag, "_sat_err_cnt"}, err_cnt_s, errs);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int c;
        c = 0;
        while (done !== 1'b1 && c < limit) begin
            step();
            c++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_sat_done"}, done_s, 1);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    task automatic start_window(input string tag, input int n);
        logic [31:0] v;
        v = n;
        NUM_SAMPLES = v[CNT_W-1:0];
        START = 1'b1;
        step();
        START = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check_counts({tag, "_start"}, 0, 0, 0);
    endtask

    // Plays the queued samples with random gaps; the monitor must keep only the first n.
    task automatic run_window(input string tag, input int n, input bit mid_start);
        int cnt;
        int errs;
        int eds;
        start_window(tag, n);
        foreach (q[i]) begin
            repeat ($urandom_range(0, 2)) step();
            drive_sample(q[i]);
            if (mid_start && i == 1) begin
                NUM_SAMPLES = NUM_SAMPLES + 16'd3;
                START = 1'b1;
            end
            step();
            VALID_IN = 1'b0;
            START = 1'b0;
        end
        wait_done(tag, 10);
        cnt = 0;
        errs = 0;
        eds = 0;
        foreach (q[i]) begin
            if (i < n) begin
                cnt++;
                if (ed_of(q[i]) != 0) errs++;
                eds += ed_of(q[i]);
            end
        end
        check_counts(tag, cnt, errs, eds);
    endtask

    task automatic push(input int a, input int b, input int cin, input int sum, input int cout);
        sample_t s;
        s.a = a; s.b = b; s.cin = cin; s.sum = sum; s.cout = cout;
        q.push_back(s);
    endtask

    initial begin
        int n;
        RST_N = 1'b1;
        START = 1'b0;
        CLEAR = 1'b0;
        NUM_SAMPLES = '0;
        VALID_IN = 1'b0;
        A = '0; B = '0; CIN = 1'b0; SUM = '0; COUT = 1'b0;
        #3 RST_N = 1'b0;
        step();
        step();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check_counts("reset", 0, 0, 0);
        RST_N = 1'b1;
        step();

        // Exact adder results: no errors
        q.delete();
        repeat (3) push(3, 12, 0, 15, 0);
        run_window("t1", 3, 1'b0);

        // ED 8 then ED 1
        q.delete();
        push(11, 12, 1, 0, 1);
        push(3, 4, 1, 7, 0);
        run_window("t2", 2, 1'b0);

        // CLEAR mid-window after two samples
        q.delete();
        start_window("t3", 4);
        drive_sample(rand_sample());
        step();
        VALID_IN = 1'b0;
        step();
        drive_sample(rand_sample());
        step();
        VALID_IN = 1'b0;
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
        check("t3_busy", busy, 0);
        check("t3_done", done, 0);
        check_counts("t3_clear", 0, 0, 0);
        repeat (3) begin
            drive_sample(rand_sample());
            step();
        end
        VALID_IN = 1'b0;
        step();
        step();
        check("t3_after_busy", busy, 0);
        check_counts("t3_after", 0, 0, 0);

        // Six samples of ED 8: narrow accumulator saturates at 31
        q.delete();
        repeat (6) push(0, 0, 0, 8, 0);
        run_window("t4", 6, 1'b0);

        // Zero-length window, extra samples ignored
        start_window("t5", 0);
        drive_sample(rand_sample());
        wait_done("t5", 3);
        VALID_IN = 1'b0;
        check_counts("t5", 0, 0, 0);

        // Asynchronous reset mid-window
        q.delete();
        start_window("t6", 5);
        drive_sample(rand_sample());
        step();
        drive_sample(rand_sample());
        step();
        VALID_IN = 1'b0;
        step();
        check("t6_latency_cnt", sample_cnt, 2);
        #2 RST_N = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_cnt", sample_cnt, 0);
        #1 RST_N = 1'b1;
        step();
        q.delete();
        repeat (4) q.push_back(rand_sample());
        run_window("t6_fresh", 4, 1'b0);

        // Randomized windows, some with extra samples and an ignored mid-run START
        for (int w = 0; w < 8; w++) begin
            n = int'($urandom_range(1, 10));
            q.delete();
            repeat (n + int'($urandom_range(0, 3))) q.push_back(rand_sample());
            run_window($sformatf("rnd%0d", w), n, (n >= 3) && (w % 2 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
